// File: rtl/mat_outer_prod.sv
// 3x3 int8 outer-product generator: loads A and B, streams P_k = A[:,k] x B[k,:].
// Build option MAT_OUTER_PROD_SAT_EN saturates each product to int8 instead of wrapping.
module mat_outer_prod (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clk_e,
  input  logic [7:0] s_axis_data,
  input  logic       s_axis_valid,
  output logic       s_axis_ready,
  input  logic       s_axis_last,
  output logic [7:0] m_axis_data,
  output logic       m_axis_valid,
  input  logic       m_axis_ready,
  output logic       m_axis_last,
  output logic       o_frame_err
);

  typedef enum logic {
    ST_LOAD,
    ST_EMIT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  idx_q;
  logic [1:0]  k_q;
  logic [1:0]  i_q;
  logic [1:0]  j_q;
  logic [7:0]  mem_q [18];
  logic        err_q;

  logic        s_fire;
  logic        m_fire;
  logic        idx_last;
  logic        beat_last;
  logic [4:0]  a_idx;
  logic [4:0]  b_idx;
  logic signed [7:0] a_op;
  logic signed [7:0] b_op;
  logic signed [7:0] res;

  assign s_axis_ready = (state_q == ST_LOAD);
  assign m_axis_valid = (state_q == ST_EMIT);

  assign s_fire = s_axis_valid & s_axis_ready & i_clk_e;
  assign m_fire = m_axis_valid & m_axis_ready & i_clk_e;

  assign idx_last  = (idx_q == 5'd17);
  assign beat_last = (k_q == 2'd2) & (i_q == 2'd2)
                   & (j_q == 2'd2);

  assign m_axis_last = m_axis_valid & beat_last;
  assign o_frame_err = err_q;

  // A[i][k] lives at 3*i+k, B[k][j] at 9+3*k+j.
  assign a_idx = {3'b000, i_q} + {3'b000, i_q}
               + {3'b000, i_q} + {3'b000, k_q};
  assign b_idx = 5'd9
               + {3'b000, k_q} + {3'b000, k_q}
               + {3'b000, k_q} + {3'b000, j_q};

  assign a_op = mem_q[a_idx];
  assign b_op = mem_q[b_idx];

`ifdef MAT_OUTER_PROD_SAT_EN
  logic signed [15:0] a_ext;
  logic signed [15:0] b_ext;
  logic signed [15:0] prod_f;

  assign a_ext  = $signed({{8{a_op[7]}}, a_op});
  assign b_ext  = $signed({{8{b_op[7]}}, b_op});
  assign prod_f = a_ext * b_ext;

  // Clamp the full product into the int8 range.
  always_comb begin
    res = prod_f[7:0];
    if (prod_f > 16'sd127) begin
      res = 8'sd127;
    end else if (prod_f < -16'sd128) begin
      res = -8'sd128;
    end
  end
`else
  // 8-bit context keeps only the low byte: modular wrap.
  assign res = a_op * b_op;
`endif

  assign m_axis_data = m_axis_valid ? res : 8'h00;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_LOAD;
    end else if (i_clk_e) begin
      state_q <= state_d;
    end
  end

  // Next state: beat count ends LOAD, last term ends EMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (s_fire && idx_last) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (m_fire && beat_last) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Load index walks 0..17 over the operand frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q <= 5'd0;
    end else if (s_fire) begin
      idx_q <= idx_last ? 5'd0 : idx_q + 5'd1;
    end
  end

  // Operand storage, cleared on reset, kept after EMIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 18; n++) begin
        mem_q[n] <= 8'h00;
      end
    end else if (s_fire) begin
      mem_q[idx_q] <= s_axis_data;
    end
  end

  // Nested k/i/j beat counters, j innermost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q <= 2'd0;
      i_q <= 2'd0;
      j_q <= 2'd0;
    end else if (m_fire) begin
      if (j_q == 2'd2) begin
        j_q <= 2'd0;
        if (i_q == 2'd2) begin
          i_q <= 2'd0;
          k_q <= (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
        end else begin
          i_q <= i_q + 2'd1;
        end
      end else begin
        j_q <= j_q + 2'd1;
      end
    end
  end

  // Flag an accepted beat whose last bit disagrees with the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (i_clk_e) begin
      err_q <= s_fire & (s_axis_last != idx_last);
    end
  end

endmodule

// File: tb/tb_mat_outer_prod.sv
// Directed bench for mat_outer_prod.
// Covers identity/ramp, overflow table, stall, clock enable, framing, reset.
module tb_mat_outer_prod;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_clk_e = 1'b1;
  logic [7:0] s_axis_data = 8'h00;
  logic       s_axis_valid = 1'b0;
  logic       s_axis_ready;
  logic       s_axis_last = 1'b0;
  logic [7:0] m_axis_data;
  logic       m_axis_valid;
  logic       m_axis_ready = 1'b0;
  logic       m_axis_last;
  logic       o_frame_err;

  mat_outer_prod dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clk_e      (i_clk_e),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .o_frame_err  (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int  checks = 0;
  int  errors = 0;
  int  err_seen;
  int  rdy_bad;
  int  got_n;
  byte got_data [27];
  bit  got_last [27];
  byte exp_id [27];
  byte id_fr [18];
  byte fr [18];

  typedef struct {
    byte a;
    byte b;
    byte wrap;
    byte sat;
  } ovf_t;

  ovf_t ovf [7];

  localparam logic [17:0] LAST_OK  = 18'h20000;
  localparam logic [17:0] LAST_B10 = 18'h20400;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic load_frame(input byte f [18],
                            input logic [17:0] lmask,
                            input bit alt);
    int  b = 0;
    int  guard = 0;
    bit  ce = 1'b1;
    bit  rdy;
    err_seen = 0;
    while (b < 18 && guard < 200) begin
      ce = alt ? ~ce : 1'b1;
      i_clk_e = ce;
      s_axis_valid = 1'b1;
      s_axis_data = f[b];
      s_axis_last = lmask[b];
      rdy = s_axis_ready;
      @(posedge i_clk);
      #1;
      if (rdy && ce) b++;
      err_seen += int'(o_frame_err);
      guard++;
    end
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    i_clk_e = 1'b1;
    chk("load_beats", b, 18);
    chk("valid_rise", int'(m_axis_valid), 1);
  endtask

  task automatic collect(input int stop_at, input int stall_at,
                         input int stall_len, input bit alt);
    int guard = 0;
    int sl = stall_len;
    bit ce = 1'b1;
    bit rdy;
    got_n = 0;
    rdy_bad = 0;
    while (got_n < stop_at && guard < 400) begin
      ce = alt ? ~ce : 1'b1;
      rdy = 1'b1;
      if (got_n == stall_at && sl > 0) begin
        rdy = 1'b0;
        sl--;
        chk("stall_valid", int'(m_axis_valid), 1);
        chk("stall_data", int'(byte'(m_axis_data)),
            int'(exp_id[stall_at]));
      end
      i_clk_e = ce;
      m_axis_ready = rdy;
      if (s_axis_ready) rdy_bad++;
      if (m_axis_valid && rdy && ce) begin
        got_data[got_n] = m_axis_data;
        got_last[got_n] = m_axis_last;
        got_n++;
      end
      @(posedge i_clk);
      #1;
      guard++;
    end
    m_axis_ready = 1'b0;
    i_clk_e = 1'b1;
    chk("emit_beats", got_n, stop_at);
    chk("sready_low_in_emit", rdy_bad, 0);
  endtask

  task automatic check_id(input string tag);
    int nl = 0;
    for (int n = 0; n < 27; n++) begin
      chk($sformatf("%s_beat%0d", tag, n),
          int'(got_data[n]), int'(exp_id[n]));
      nl += int'(got_last[n]);
    end
    chk({tag, "_last26"}, int'(got_last[26]), 1);
    chk({tag, "_nlast"}, nl, 1);
    chk({tag, "_sready_back"}, int'(s_axis_ready), 1);
    chk({tag, "_valid_drop"}, int'(m_axis_valid), 0);
  endtask

  initial begin
    exp_id = '{1, 2, 3, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 4, 5, 6, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 7, 8, 9};
    for (int n = 0; n < 9; n++) begin
      id_fr[n] = (n % 4 == 0) ? 8'sd1 : 8'sd0;
      id_fr[9 + n] = byte'(n + 1);
    end
    ovf[0] = '{a: 16,   b: 16,   wrap: 0,    sat: 127};
    ovf[1] = '{a: -128, b: -128, wrap: 0,    sat: 127};
    ovf[2] = '{a: -3,   b: 5,    wrap: -15,  sat: -15};
    ovf[3] = '{a: 127,  b: 127,  wrap: 1,    sat: 127};
    ovf[4] = '{a: -1,   b: -1,   wrap: 1,    sat: 1};
    ovf[5] = '{a: 7,    b: -9,   wrap: -63,  sat: -63};
    ovf[6] = '{a: -128, b: 127,  wrap: -128, sat: -128};

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_sready", int'(s_axis_ready), 1);
    chk("rst_mvalid", int'(m_axis_valid), 0);
    chk("rst_mlast", int'(m_axis_last), 0);
    chk("rst_mdata", int'(m_axis_data), 0);
    chk("rst_err", int'(o_frame_err), 0);
    i_rst = 1'b0;

    load_frame(id_fr, LAST_OK, 1'b0);
    chk("id_err", err_seen, 0);
    collect(27, -1, 0, 1'b0);
    check_id("id");

    for (int v = 0; v < 7; v++) begin
      for (int n = 0; n < 18; n++) fr[n] = 0;
      fr[0] = ovf[v].a;
      fr[9] = ovf[v].b;
      load_frame(fr, LAST_OK, 1'b0);
      collect(27, -1, 0, 1'b0);
`ifdef MAT_OUTER_PROD_SAT_EN
      chk($sformatf("ovf%0d", v), int'(got_data[0]),
          int'(ovf[v].sat));
`else
      chk($sformatf("ovf%0d", v), int'(got_data[0]),
          int'(ovf[v].wrap));
`endif
    end

    load_frame(id_fr, LAST_OK, 1'b0);
    collect(27, 4, 5, 1'b0);
    check_id("stall");

    load_frame(id_fr, LAST_OK, 1'b1);
    chk("ce_err", err_seen, 0);
    collect(27, -1, 0, 1'b1);
    check_id("ce");

    load_frame(id_fr, LAST_B10, 1'b0);
    chk("frame_err_once", err_seen, 1);
    collect(27, -1, 0, 1'b0);
    check_id("ferr");

    load_frame(id_fr, LAST_OK, 1'b0);
    collect(12, -1, 0, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("mrst_mvalid", int'(m_axis_valid), 0);
    chk("mrst_sready", int'(s_axis_ready), 1);
    chk("mrst_mdata", int'(m_axis_data), 0);
    chk("mrst_err", int'(o_frame_err), 0);
    load_frame(id_fr, LAST_OK, 1'b0);
    collect(27, -1, 0, 1'b0);
    check_id("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_outer_prod.md
Name: mat_outer_prod

Overview:
- Upstream stage of the 3x3 int8 matrix-multiply accumulator.
- Loads one 3x3 matrix A and one 3x3 matrix B from an 8-bit AXI-Stream.
- Emits three 9-element outer-product matrices P_k[i][j] = A[i][k]*B[k][j], k = 0..2, each row-major, as 27 consecutive beats.
- The downstream accumulator sums the three P_k to form C = A*B.

Parameters:
- None. Matrix dimension is fixed at 3x3; data width is fixed at 8 bits, signed.

Ports:
- i_clk  in  1  system clock; one clock domain; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_clk_e  in  1  clock enable; when low, no state, counter or storage changes.
- s_axis_data  in  8  signed operand byte: beats 0..8 = A row-major, beats 9..17 = B row-major.
- s_axis_valid  in  1  operand beat valid.
- s_axis_ready  out  1  high while in LOAD.
- s_axis_last  in  1  marks beat 17 of the operand frame.
- m_axis_data  out  8  signed product term, low 8 bits of the product (see Optional Feature).
- m_axis_valid  out  1  high while in EMIT.
- m_axis_ready  in  1  downstream accept.
- m_axis_last  out  1  high on beat 26, the final term of P_2.
- o_frame_err  out  1  one-cycle pulse on s_axis_last mismatch.

Behaviour:
- Reset (i_rst high at a rising edge, regardless of i_clk_e):
  - state = LOAD; load index = 0; k/i/j counters = 0.
  - All 18 storage bytes cleared to 0.
  - Resulting output values: s_axis_ready = 1, m_axis_valid = 0, m_axis_last = 0, m_axis_data = 0, o_frame_err = 0.
  - Reset mid-frame or mid-emit discards everything; the next accepted beat is A[0][0].
- Handshake on either interface counts only when valid && ready && i_clk_e are all high.
- LOAD state:
  - Each accepted beat writes storage[idx] and increments idx, 0..17.
  - On the accepted beat with idx = 17: idx <= 0, state <= EMIT.
  - s_axis_last is not used for framing; the beat count alone defines the frame.
  - o_frame_err pulses for one cycle when s_axis_last disagrees with (idx == 17) on an accepted beat.
- EMIT state:
  - Beat order: nested counters k (outer), i, j (inner), all 0..2.
  - m_axis_data = f(A[i][k]*B[k][j]); full 16-bit signed product, reduced per Optional Feature.
  - Data path is combinational from storage and counters; it must be stable while m_axis_valid && !m_axis_ready.
  - m_axis_last = (k == 2 && i == 2 && j == 2) while in EMIT.
  - On the accepted last beat: counters <= 0, state <= LOAD.
- Latency:
  - m_axis_valid rises the cycle after the 18th operand beat is accepted.
  - One output beat per cycle with no bubbles when m_axis_ready and i_clk_e are held high, giving 27 cycles of EMIT.
  - LOAD and EMIT never overlap; s_axis_ready = 0 throughout EMIT.
- i_clk_e low: all outputs hold their values; no handshake completes on either side.
- Storage content persists after EMIT; it is overwritten by the next frame.

Optional Feature:
- Macro: MAT_OUTER_PROD_SAT_EN.
- Defined: the 16-bit product is saturated to [-128, 127] before output.
- Undefined (default): m_axis_data = product[7:0], two's-complement wrap. This matches the downstream accumulator's modular int8 arithmetic.

Test Plan:
- Identity x ramp: A = I, B = 1..9 with s_axis_last on beat 17 -> 27 beats:
  - P_0 = 1,2,3,0,0,0,0,0,0
  - P_1 = 0,0,0,4,5,6,0,0,0
  - P_2 = 0,0,0,0,0,0,7,8,9
  - m_axis_last only on beat 26; s_axis_ready returns to 1 the next cycle; o_frame_err never pulses.
- Overflow: A[0][0] = 16, B[0][0] = 16, and separately A[0][0] = -128, B[0][0] = -128 -> beat 0 reads:
  - without MAT_OUTER_PROD_SAT_EN: 0 (256 -> 0x00) and 0 (16384 -> 0x00)
  - with MAT_OUTER_PROD_SAT_EN: 127 in both cases
  - A[0][0] = -3, B[0][0] = 5 -> -15 in both builds.
- Backpressure: identity/ramp frame; m_axis_ready low for 5 cycles at output beat 4 -> m_axis_data holds 0 and m_axis_valid stays 1 for all 5 cycles; the full 27-beat sequence is unchanged.
- Clock enable: i_clk_e low on alternate cycles during both LOAD and EMIT -> identical output sequence; no beat accepted or emitted in an enable-low cycle.
- Framing error: s_axis_last asserted on beat 10 -> o_frame_err pulses once; loading continues; EMIT starts after beat 17.
- Reset mid-EMIT: assert i_rst at output beat 12 -> next cycle m_axis_valid = 0, s_axis_ready = 1, m_axis_data = 0; a new frame loads and emits correctly.
